// File: rtl/cc_expun_queue_pkg.sv
// Shared constants and state encoding for the expunge queue
// that sits behind the ccTag ways.
package cc_expun_queue_pkg;

    localparam int CC_EXPUN_AW = 37;

    typedef enum logic [1:0] {
        EXPQ_RUN   = 2'd0,
        EXPQ_FLUSH = 2'd1,
        EXPQ_CLEAR = 2'd2
    } expq_state_t;

    // True when two or more request bits are set in the same cycle.
    function automatic logic multi_hot(input logic [31:0] v);
        return |(v & (v - 32'd1));
    endfunction

endpackage

// File: rtl/cc_expun_queue_if.sv
// Fill-side, back-invalidate and control signals of the expunge queue.
// The slave modport is the queue itself, and the master modport is its environment.
interface cc_expun_queue_if #(
    parameter int WAYS  = 4,
    parameter int DEPTH = 8,
    parameter int AW    = cc_expun_queue_pkg::CC_EXPUN_AW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WAYS-1:0]         exp_en;
    logic [WAYS-1:0][AW-1:0] exp_addr;
    logic                    exp_stall;
    logic                    inv_valid;
    logic [AW-1:0]           inv_addr;
    logic                    inv_ready;
    logic [AW-1:0]           lookup_addr;
    logic                    lookup_hit;
    logic                    flush;
    logic                    flush_done;
    logic                    init;
    logic [CW-1:0]           count;
    logic [1:0]              err;

    modport slave (
        input  exp_en, exp_addr, inv_ready, lookup_addr, flush, init,
        output exp_stall, inv_valid, inv_addr, lookup_hit, flush_done, count, err
    );

    modport master (
        output exp_en, exp_addr, inv_ready, lookup_addr, flush, init,
        input  exp_stall, inv_valid, inv_addr, lookup_hit, flush_done, count, err
    );

endinterface

// File: rtl/cc_expun_store.sv
// Entry array with per-entry valid bits, one write port, and a head read port.
// It also has two CAM compare vectors, one for dedup and one for lookup.
module cc_expun_store #(
    parameter int DEPTH = 8,
    parameter int AW    = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [AW-1:0]            wr_addr,
    input  logic                     rd_pop,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [AW-1:0]            rd_addr,
    input  logic [AW-1:0]            dedup_addr,
    output logic [DEPTH-1:0]         dedup_match,
    input  logic [AW-1:0]            lookup_addr,
    output logic [DEPTH-1:0]         lookup_match
);
    logic [AW-1:0]    entry [DEPTH];
    logic [DEPTH-1:0] valid;

    // When the queue is full, a push and a pop in the same cycle hit the same slot.
    // The write is placed last so that it wins.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else if (clear) begin
            valid <= '0;
        end else begin
            if (rd_pop) valid[rd_idx] <= 1'b0;
            if (wr_en) begin
                entry[wr_idx] <= wr_addr;
                valid[wr_idx] <= 1'b1;
            end
        end
    end

    assign rd_addr = entry[rd_idx];

    always_comb begin
        dedup_match  = '0;
        lookup_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dedup_match[i]  = valid[i] && (entry[i] == dedup_addr);
            lookup_match[i] = valid[i] && (entry[i] == lookup_addr);
        end
    end

endmodule

// File: rtl/cc_expun_queue.sv
// Buffers ccTag victim addresses and replays them as back-invalidates to L1.
// It provides back-pressure, a pending-address lookup, flush and init.
module cc_expun_queue
    import cc_expun_queue_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int DEPTH = 8,
    parameter int AW    = CC_EXPUN_AW
) (
    input logic             clk,
    input logic             rst,
    cc_expun_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_COUNT = CW'(DEPTH - 1);

    expq_state_t      state, state_next;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [1:0]       err;
    logic             flush_done, done_next;
    logic             active, sel_any, multi, dup, full;
    logic             inv_valid, pop, push_req, push_acc, drop_full;
    logic [AW-1:0]    sel_addr, head_addr;
    logic [DEPTH-1:0] dedup_match, lookup_match;

    // The lowest-index way wins. Scanning from the top lets the lowest way overwrite the others.
    always_comb begin
        sel_addr = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (bus.exp_en[w]) sel_addr = bus.exp_addr[w];
        end
    end

    assign active    = !bus.init && (state != EXPQ_CLEAR);
    assign sel_any   = |bus.exp_en;
    assign multi     = active && multi_hot(32'(bus.exp_en));
    assign dup       = |dedup_match;
    assign full      = (count == FULL_COUNT);
    assign inv_valid = (count != '0) && (state != EXPQ_CLEAR);
    assign pop       = inv_valid && bus.inv_ready && !bus.init;
    assign push_req  = active && sel_any && !dup;
    assign push_acc  = push_req && (!full || pop);
    assign drop_full = push_req && full && !pop;

    cc_expun_store #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) store (
        .clk         (clk),
        .rst         (rst),
        .clear       (bus.init),
        .wr_en       (push_acc),
        .wr_idx      (tail),
        .wr_addr     (sel_addr),
        .rd_pop      (pop),
        .rd_idx      (head),
        .rd_addr     (head_addr),
        .dedup_addr  (sel_addr),
        .dedup_match (dedup_match),
        .lookup_addr (bus.lookup_addr),
        .lookup_match(lookup_match)
    );

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EXPQ_RUN;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            flush_done <= done_next;
        end
    end

    // A drain finishes only when a push that was still in flight does not refill the queue.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (bus.init) begin
            state_next = EXPQ_CLEAR;
        end else begin
            case (state)
                EXPQ_RUN:   if (bus.flush) state_next = EXPQ_FLUSH;
                EXPQ_FLUSH: begin
                    if (count == '0 && !push_acc) begin
                        state_next = EXPQ_RUN;
                        done_next  = 1'b1;
                    end
                end
                EXPQ_CLEAR: state_next = EXPQ_RUN;
                default:    state_next = EXPQ_RUN;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= '0;
        end else if (bus.init) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= '0;
        end else begin
            if (push_acc) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push_acc) - CW'(pop);
            err   <= err | {drop_full, multi};
        end
    end

    assign bus.inv_valid  = inv_valid;
    assign bus.inv_addr   = head_addr;
    assign bus.exp_stall  = (count >= STALL_COUNT) || (state != EXPQ_RUN);
    assign bus.lookup_hit = (|lookup_match) && (state != EXPQ_CLEAR);
    assign bus.flush_done = flush_done;
    assign bus.count      = count;
    assign bus.err        = err;

endmodule

// File: tb/tb_cc_expun_queue.sv
// Testbench for cc_expun_queue. Directed scenarios and a randomized run are checked
// against a queue-based reference model.
module tb_cc_expun_queue;
    localparam int WAYS  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 37;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [AW-1:0] m_q[$];
    logic [1:0]    m_err;
    bit            m_fl, m_cl, m_done;
    logic [AW-1:0] pool [12];

    cc_expun_queue_if #(.WAYS(WAYS), .DEPTH(DEPTH), .AW(AW)) bus ();

    cc_expun_queue #(.WAYS(WAYS), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit in_q(input logic [AW-1:0] a);
        foreach (m_q[i]) if (m_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_err  = 2'b00;
        m_fl   = 1'b0;
        m_cl   = 1'b0;
        m_done = 1'b0;
    endtask

    // Models one state-updating edge directly from the queue behaviour rules.
    task automatic model_step();
        int            n, nset;
        bit            do_pop, pushed, any;
        logic [AW-1:0] a;
        n = m_q.size();
        if (bus.init) begin
            model_reset();
            m_cl = 1'b1;
            return;
        end
        m_done = 1'b0;
        if (m_cl) begin
            m_cl = 1'b0;
            return;
        end
        do_pop = (n > 0) && bus.inv_ready;
        nset = 0;
        any  = 1'b0;
        a    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.exp_en[w]) begin
                if (!any) a = bus.exp_addr[w];
                any = 1'b1;
                nset++;
            end
        end
        if (nset > 1) m_err[0] = 1'b1;
        pushed = 1'b0;
        if (any && !in_q(a)) begin
            if (n < DEPTH || do_pop) pushed = 1'b1;
            else m_err[1] = 1'b1;
        end
        if (do_pop) void'(m_q.pop_front());
        if (pushed) m_q.push_back(a);
        if (m_fl) begin
            if (n == 0 && !pushed) begin
                m_fl   = 1'b0;
                m_done = 1'b1;
            end
        end else if (bus.flush) begin
            m_fl = 1'b1;
        end
    endtask

    task automatic drive_idle();
        bus.exp_en      = '0;
        bus.exp_addr    = '0;
        bus.inv_ready   = 1'b0;
        bus.lookup_addr = '0;
        bus.flush       = 1'b0;
        bus.init        = 1'b0;
    endtask

    task automatic advance();
        @(negedge clk);
        if (rst) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int way, input logic [AW-1:0] a);
        bus.exp_en          = '0;
        bus.exp_en[way]     = 1'b1;
        bus.exp_addr[way]   = a;
        advance();
        bus.exp_en          = '0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.inv_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_inv_valid: got %b want 0", bus.inv_valid); end
        n_cmp++; if (bus.exp_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %b want 0", bus.exp_stall); end
        n_cmp++; if (bus.flush_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_flush_done: got %b want 0", bus.flush_done); end
        n_cmp++; if (bus.err !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 00", bus.err); end
        rst = 1'b1;
        advance();
    endtask

    task automatic test_pass_through();
        bus.exp_addr    = {37'h1111, 37'h2222, 37'h3333, 37'h4444};
        bus.exp_addr[2] = 37'h1A2B;
        bus.exp_en      = 4'b0100;
        bus.inv_ready   = 1'b1;
        advance();
        bus.exp_en = '0;
        n_cmp++; if (bus.inv_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL pass_valid: got %b want 1", bus.inv_valid); end
        n_cmp++; if (bus.inv_addr !== 37'h1A2B) begin n_bad++; $display("[TB] FAIL pass_addr: got %0h want 1a2b", bus.inv_addr); end
        n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("[TB] FAIL pass_count1: got %0d want 1", bus.count); end
        advance();
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("[TB] FAIL pass_count0: got %0d want 0", bus.count); end
        bus.inv_ready = 1'b0;
    endtask

    task automatic test_dedup_lookup();
        bus.inv_ready = 1'b0;
        push_one(1, 37'h55);
        push_one(1, 37'h55);
        n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("[TB] FAIL dedup_count: got %0d want 1", bus.count); end
        bus.lookup_addr = 37'h55;
        #1;
        n_cmp++; if (bus.lookup_hit !== 1'b1) begin n_bad++; $display("[TB] FAIL lookup_hit: got %b want 1", bus.lookup_hit); end
        bus.lookup_addr = 37'h56;
        #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL lookup_miss: got %b want 0", bus.lookup_hit); end
        bus.lookup_addr = 37'h55;
        bus.inv_ready   = 1'b1;
        advance();
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL lookup_after_pop: got %b want 0", bus.lookup_hit); end
        bus.inv_ready = 1'b0;
    endtask

    task automatic test_multi_way();
        bus.exp_addr[1] = 37'hAAA;
        bus.exp_addr[3] = 37'hBBB;
        bus.exp_en      = 4'b1010;
        advance();
        bus.exp_en = '0;
        n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("[TB] FAIL multi_count: got %0d want 1", bus.count); end
        n_cmp++; if (bus.inv_addr !== 37'hAAA) begin n_bad++; $display("[TB] FAIL multi_addr: got %0h want aaa", bus.inv_addr); end
        n_cmp++; if (bus.err !== 2'b01) begin n_bad++; $display("[TB] FAIL multi_err: got %b want 01", bus.err); end
        bus.lookup_addr = 37'hBBB;
        #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL multi_loser_hit: got %b want 0", bus.lookup_hit); end
        bus.inv_ready = 1'b1;
        advance();
        bus.inv_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 9; i++) begin
            push_one(0, 37'h100 + 37'(i));
            n_cmp++;
            if (bus.count !== 4'((i < DEPTH) ? i + 1 : DEPTH)) begin
                n_bad++; $display("[TB] FAIL bp_count%0d: got %0d want %0d", i, bus.count, (i < DEPTH) ? i + 1 : DEPTH);
            end
            n_cmp++;
            if (bus.exp_stall !== (i >= 6)) begin
                n_bad++; $display("[TB] FAIL bp_stall%0d: got %b want %b", i, bus.exp_stall, i >= 6);
            end
            n_cmp++;
            if (bus.err[1] !== (i == 8)) begin
                n_bad++; $display("[TB] FAIL bp_err%0d: got %b want %b", i, bus.err[1], i == 8);
            end
        end
        bus.inv_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (bus.inv_valid !== 1'b1 || bus.inv_addr !== 37'h100 + 37'(i)) begin
                n_bad++; $display("[TB] FAIL bp_drain%0d: got %b/%0h want 1/%0h", i, bus.inv_valid, bus.inv_addr, 37'h100 + 37'(i));
            end
            advance();
        end
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("[TB] FAIL bp_empty: got %0d want 0", bus.count); end
        bus.inv_ready = 1'b0;
    endtask

    task automatic test_flush();
        int pulses;
        bit seen;
        for (int i = 0; i < 3; i++) push_one(2, 37'h400 + 37'(i));
        bus.flush     = 1'b1;
        bus.inv_ready = 1'b1;
        advance();
        bus.flush = 1'b0;
        pulses = 0;
        seen   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.flush_done === 1'b1) begin
                pulses++;
                seen = 1'b1;
            end
            n_cmp++; if (bus.flush_done !== m_done) begin n_bad++; $display("[TB] FAIL flush_done_c%0d: got %b want %b", c, bus.flush_done, m_done); end
            n_cmp++; if (bus.exp_stall !== !seen) begin n_bad++; $display("[TB] FAIL flush_stall_c%0d: got %b want %b", c, bus.exp_stall, !seen); end
            advance();
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL flush_pulses: got %0d want 1", pulses); end
        bus.flush = 1'b1;
        advance();
        bus.flush = 1'b0;
        n_cmp++; if (bus.flush_done !== 1'b0 || bus.exp_stall !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_empty_entry: got done=%b stall=%b want 0/1", bus.flush_done, bus.exp_stall); end
        advance();
        n_cmp++; if (bus.flush_done !== 1'b1 || bus.exp_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_empty_done: got done=%b stall=%b want 1/0", bus.flush_done, bus.exp_stall); end
        bus.inv_ready = 1'b0;
        advance();
    endtask

    task automatic test_init();
        for (int i = 0; i < 5; i++) push_one(3, 37'h200 + 37'(i));
        n_cmp++; if (bus.inv_valid !== 1'b1 || bus.err !== 2'b11) begin n_bad++; $display("[TB] FAIL init_pre: got valid=%b err=%b want 1/11", bus.inv_valid, bus.err); end
        bus.init        = 1'b1;
        bus.inv_ready   = 1'b1;
        bus.lookup_addr = 37'h200;
        advance();
        bus.init = 1'b0;
        n_cmp++; if (bus.inv_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL init_valid: got %b want 0", bus.inv_valid); end
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("[TB] FAIL init_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.err !== 2'b00) begin n_bad++; $display("[TB] FAIL init_err: got %b want 00", bus.err); end
        n_cmp++; if (bus.exp_stall !== 1'b1 || bus.lookup_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL init_clear_outputs: got stall=%b hit=%b want 1/0", bus.exp_stall, bus.lookup_hit); end
        advance();
        n_cmp++; if (bus.exp_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL init_run_stall: got %b want 0", bus.exp_stall); end
        bus.inv_ready = 1'b0;
    endtask

    task automatic test_reset_midpop();
        push_one(0, 37'h300);
        push_one(0, 37'h301);
        bus.inv_ready = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("[TB] FAIL async_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.inv_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL async_valid: got %b want 0", bus.inv_valid); end
        model_reset();
        bus.inv_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        advance();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            bus.exp_en = (r < 4) ? 4'b0000 : (r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            for (int w = 0; w < WAYS; w++) bus.exp_addr[w] = pool[$urandom_range(0, 11)];
            bus.inv_ready   = ((c / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.lookup_addr = pool[$urandom_range(0, 11)];
            bus.flush       = ($urandom_range(0, 24) == 0);
            bus.init        = ($urandom_range(0, 79) == 0);
            #1;
            n_cmp++; if (bus.count !== 4'(m_q.size())) begin n_bad++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, m_q.size()); end
            n_cmp++; if (bus.inv_valid !== (m_q.size() > 0 && !m_cl)) begin n_bad++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, bus.inv_valid, m_q.size() > 0 && !m_cl); end
            if (m_q.size() > 0 && !m_cl) begin
                n_cmp++; if (bus.inv_addr !== m_q[0]) begin n_bad++; $display("[TB] FAIL rnd_addr c%0d: got %0h want %0h", c, bus.inv_addr, m_q[0]); end
            end
            n_cmp++; if (bus.exp_stall !== (m_q.size() >= DEPTH - 1 || m_fl || m_cl)) begin n_bad++; $display("[TB] FAIL rnd_stall c%0d: got %b", c, bus.exp_stall); end
            n_cmp++; if (bus.lookup_hit !== (in_q(bus.lookup_addr) && !m_cl)) begin n_bad++; $display("[TB] FAIL rnd_lookup c%0d: got %b", c, bus.lookup_hit); end
            n_cmp++; if (bus.flush_done !== m_done) begin n_bad++; $display("[TB] FAIL rnd_flush_done c%0d: got %b want %b", c, bus.flush_done, m_done); end
            n_cmp++; if (bus.err !== m_err) begin n_bad++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", c, bus.err, m_err); end
            advance();
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        for (int i = 0; i < 12; i++) pool[i] = {5'($urandom), 32'($urandom)};
        test_reset();
        test_pass_through();
        test_dedup_lookup();
        test_multi_way();
        test_backpressure();
        test_flush();
        test_init();
        test_reset_midpop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
